// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: instruction memory, program counter and
// IDLE/RUN/HALTED sequencing feeding the 9-bit OPCODE to the control decoder.
module instr_fetch #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [PC_W-1:0]    START_ADDR,
  input  logic               PROG_WE,
  input  logic [PC_W-1:0]    PROG_ADDR,
  input  logic [INSTR_W-1:0] PROG_DATA,
  input  logic               HALT,
  input  logic               BRANCH,
  input  logic               BRANCH_TAKEN,
  input  logic [PC_W-1:0]    BR_TARGET,
  output logic [INSTR_W-1:0] OPCODE,
  output logic [PC_W-1:0]    PC,
  output logic               VALID,
  output logic               DONE,
  output logic [CNT_W-1:0]   CYCLE_CNT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam int DEPTH = 2 ** PC_W;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               imem_we;

  logic [INSTR_W-1:0] imem [DEPTH];

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Program memory is deliberately outside reset so a loaded program survives it.
  always_ff @(posedge CLK) begin
    if (imem_we) imem[PROG_ADDR] <= PROG_DATA;
  end

  // Next-state / datapath update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (START) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        if (HALT) begin
          state_d = S_HALTED;
          done_d  = 1'b1;
        end else if (BRANCH && BRANCH_TAKEN) begin
          pc_d = BR_TARGET;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    imem_we   = PROG_WE && (state_q == S_IDLE) && !RESET;
    VALID     = (state_q == S_RUN);
    DONE      = done_q;
    PC        = pc_q;
    CYCLE_CNT = cnt_q;
    OPCODE    = imem[pc_q];
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: the bench plays decoder/datapath by driving
// HALT/BRANCH directly and checks PC, status and OPCODE after each edge.
module tb_instr_fetch;
  localparam int PC_W = 10, INSTR_W = 9, CNT_W = 16;

  logic               CLK = 1'b0;
  logic               RESET, START, PROG_WE, HALT, BRANCH, BRANCH_TAKEN;
  logic [PC_W-1:0]    START_ADDR, PROG_ADDR, BR_TARGET;
  logic [INSTR_W-1:0] PROG_DATA;
  logic [INSTR_W-1:0] OPCODE;
  logic [PC_W-1:0]    PC;
  logic               VALID, DONE;
  logic [CNT_W-1:0]   CYCLE_CNT;

  int tests = 0;
  int fails = 0;

  localparam logic [INSTR_W-1:0] ADD0 = 9'h0A1, ADD1 = 9'h0A2, ADD2 = 9'h0A3;
  localparam logic [INSTR_W-1:0] HT = 9'h1FF, JUNK = 9'h055, NEWW = 9'h123;

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .START_ADDR(START_ADDR),
    .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
    .HALT(HALT), .BRANCH(BRANCH), .BRANCH_TAKEN(BRANCH_TAKEN), .BR_TARGET(BR_TARGET),
    .OPCODE(OPCODE), .PC(PC), .VALID(VALID), .DONE(DONE), .CYCLE_CNT(CYCLE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [PC_W-1:0] a, input logic [INSTR_W-1:0] d);
    PROG_WE = 1'b1; PROG_ADDR = a; PROG_DATA = d;
    tick();
    PROG_WE = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b1; START_ADDR = 10'd9; PROG_WE = 1'b0;
    PROG_ADDR = '0; PROG_DATA = '0; HALT = 1'b0; BRANCH = 1'b0;
    BRANCH_TAKEN = 1'b0; BR_TARGET = '0;

    // T1: reset beats START
    tick(); tick();
    chk("rst_pc", PC, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_done", DONE, 0);
    chk("rst_cnt", CYCLE_CNT, 0);
    RESET = 1'b0; START = 1'b0;

    // T2: straight-line program
    load(0, ADD0); load(1, ADD1); load(2, ADD2); load(3, HT);
    chk("idle_opcode", OPCODE, ADD0);
    chk("idle_valid", VALID, 0);
    START = 1'b1; START_ADDR = 0;
    tick();
    START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("line_pc", PC, i);
      chk("line_valid", VALID, 1);
      if (i == 3) chk("line_ht_op", OPCODE, HT);
      HALT = (i == 3);
      tick();
    end
    HALT = 1'b0;
    chk("halt_done", DONE, 1);
    chk("halt_pc", PC, 3);
    chk("halt_cnt", CYCLE_CNT, 4);
    chk("halt_valid", VALID, 0);
    tick();
    chk("halt_hold_pc", PC, 3);
    chk("halt_hold_cnt", CYCLE_CNT, 4);

    // T3: branch taken / not taken, restart from HALTED
    START = 1'b1; START_ADDR = 5;
    tick();
    START = 1'b0;
    chk("br_start_pc", PC, 5);
    chk("br_start_done", DONE, 0);
    chk("br_start_cnt", CYCLE_CNT, 0);
    BRANCH = 1'b1; BRANCH_TAKEN = 1'b1; BR_TARGET = 20;
    tick();
    chk("br_taken_pc", PC, 20);
    BR_TARGET = 5;
    tick();
    chk("br_back_pc", PC, 5);
    BRANCH_TAKEN = 1'b0;
    tick();
    chk("br_ntaken_pc", PC, 6);

    // T4: HALT outranks a taken branch
    HALT = 1'b1; BRANCH_TAKEN = 1'b1; BR_TARGET = 20;
    tick();
    HALT = 1'b0; BRANCH = 1'b0; BRANCH_TAKEN = 1'b0;
    chk("prio_pc", PC, 6);
    chk("prio_done", DONE, 1);
    chk("prio_cnt", CYCLE_CNT, 4);
    // Decoder inputs are ignored while not VALID
    BRANCH = 1'b1; BRANCH_TAKEN = 1'b1; BR_TARGET = 40;
    tick();
    BRANCH = 1'b0; BRANCH_TAKEN = 1'b0;
    chk("idle_br_pc", PC, 6);
    // PC wrap
    START = 1'b1; START_ADDR = 10'd1023;
    tick();
    START = 1'b0;
    chk("wrap_start_pc", PC, 1023);
    tick();
    chk("wrap_pc", PC, 0);

    // T5: load gating -- write in RUN ignored
    load(0, JUNK);
    chk("run_we_pc", PC, 1);
    HALT = 1'b1;
    tick();
    HALT = 1'b0;
    chk("ht2_pc", PC, 1);
    load(1, JUNK);
    chk("halted_we_op", OPCODE, ADD1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst2_pc", PC, 0);
    chk("run_we_op", OPCODE, ADD0);
    // write + START together in IDLE
    PROG_WE = 1'b1; PROG_ADDR = 8; PROG_DATA = NEWW; START = 1'b1; START_ADDR = 8;
    tick();
    PROG_WE = 1'b0; START = 1'b0;
    chk("ws_pc", PC, 8);
    chk("ws_valid", VALID, 1);
    chk("ws_op", OPCODE, NEWW);

    // T6: reset mid-run, then re-execute retained program
    BRANCH = 1'b1; BRANCH_TAKEN = 1'b1; BR_TARGET = 7;
    tick();
    BRANCH = 1'b0; BRANCH_TAKEN = 1'b0;
    chk("mid_pc", PC, 7);
    chk("mid_cnt", CYCLE_CNT, 1);
    RESET = 1'b1; START = 1'b1;
    tick();
    RESET = 1'b0; START = 1'b0;
    chk("mid_rst_pc", PC, 0);
    chk("mid_rst_valid", VALID, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_cnt", CYCLE_CNT, 0);
    START = 1'b1; START_ADDR = 0;
    tick();
    START = 1'b0;
    chk("rerun_pc", PC, 0);
    chk("rerun_op", OPCODE, ADD0);
    tick();
    chk("rerun_pc1", PC, 1);
    chk("rerun_op1", OPCODE, ADD1);
    chk("rerun_cnt", CYCLE_CNT, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
